uart_input_buffer: RTL



---
 rtl/uart_input_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_input_buffer.sv
// UART RX front end: byte receiver, optional 4-byte big-endian word assembler (UART_INPUT_WORD_ASSEMBLY_EN)
// and a first-word-fall-through FIFO feeding write-back. Without the macro each byte is pushed zero-extended.
module uart_input_buffer #(
    parameter int CLK_PER_BIT     = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        read_request,
    output logic        input_ready,
    output logic [31:0] input_data,
    output logic        overrun,
    output logic        frame_error
);
    // state | meaning
    // IDLE  | line idle, waiting for a synchronized low
    // START | timing to mid start bit, rejecting glitches
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling stop bit, byte accepted or rejected
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam int TW = $clog2(CLK_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_TC = TW'(CLK_PER_BIT / 2);
    localparam logic [TW-1:0] BIT_TC  = TW'(CLK_PER_BIT - 1);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    state_t              state, state_nxt;
    logic                rx_meta, rx_sync, armed;
    logic [TW-1:0]       timer;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;
    logic                tick, timer_clr, shift_en, byte_ok, byte_bad;
    logic                push, pop, wr, empty, full;
    logic [31:0]         push_word;
    logic [FIFO_DEPTH_LOG2:0] wptr, rptr;
    logic [31:0]         mem [DEPTH];

    // Synchronizer resets low and 'armed' waits for an idle high, so a line held low across reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            armed   <= armed | rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (armed && !rx_sync) state_nxt = S_START;
            S_START: if (tick) state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (tick && bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tick      = (state == S_START) ? (timer == HALF_TC) : (timer == BIT_TC);
        timer_clr = (state == S_IDLE) || tick;
        shift_en  = (state == S_DATA) && tick;
        byte_ok   = (state == S_STOP) && tick && rx_sync;
        byte_bad  = (state == S_STOP) && tick && !rx_sync;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer       <= '0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            frame_error <= 1'b0;
        end else begin
            timer       <= timer_clr ? '0 : timer + TW'(1);
            bit_cnt     <= (state != S_DATA) ? 3'd0 : (shift_en ? bit_cnt + 3'd1 : bit_cnt);
            if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
            frame_error <= byte_bad;
        end
    end

`ifdef UART_INPUT_WORD_ASSEMBLY_EN
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
            word_acc <= 24'h0;
        end else if (byte_ok) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_acc <= {word_acc[15:0], shift_reg};
        end
    end

    assign push      = byte_ok && (byte_cnt == 2'd3);
    assign push_word = {word_acc, shift_reg};
`else
    assign push      = byte_ok;
    assign push_word = {24'h0, shift_reg};
`endif

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_DEPTH_LOG2] != rptr[FIFO_DEPTH_LOG2]) &&
                   (wptr[FIFO_DEPTH_LOG2-1:0] == rptr[FIFO_DEPTH_LOG2-1:0]);
    assign pop   = read_request && !empty;
    // A pop frees the slot the push lands in, so full+pop still accepts the word.
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && full && !pop) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[FIFO_DEPTH_LOG2-1:0]] <= push_word;
    end

    assign input_ready = !empty;
    assign input_data  = empty ? 32'h0 : mem[rptr[FIFO_DEPTH_LOG2-1:0]];

endmodule
